// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared definitions for the multiply/divide unit: md_op
//                encodings (also used by the CU decoder and the stall unit),
//                sequencer state encoding and default latencies.
//  Revision    : 1.0  initial release
// ============================================================================
package mdu_pkg;

    // md_op encodings, valid together with start
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    // Sequencer states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Default busy-cycle counts
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Counter width able to hold the larger of the two latencies
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_arith.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_arith
//  Description : Purely combinational MDU datapath. Computes the HI/LO result
//                of the latched operation plus a divide-by-zero flag.
//  Ports       : a_i, b_i    latched rs / rt operands
//                op_i        latched md_op
//                hi_res_o    result destined for HI
//                lo_res_o    result destined for LO
//                div_zero_o  divide op with zero divisor (suppress commit)
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  md_op_e      op_i,
    output logic [31:0] hi_res_o,
    output logic [31:0] lo_res_o,
    output logic        div_zero_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_sdiv;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Explicit sign/zero extension to 64 bits keeps the product full width
    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    // Signed division done on magnitudes. 0x80000000 has magnitude 2^31,
    // which is representable unsigned, so the overflow case
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    assign is_sdiv = (op_i == MD_DIV);
    assign a_neg   = is_sdiv & a_i[31];
    assign b_neg   = is_sdiv & b_i[31];
    assign a_mag   = a_neg ? (~a_i + 32'd1) : a_i;
    assign b_mag   = b_neg ? (~b_i + 32'd1) : b_i;

    // Avoid a zero divisor in the datapath; the result is discarded anyway
    assign div_zero_o = (b_i == 32'd0);
    assign b_safe     = div_zero_o ? 32'd1 : b_mag;

    assign q_mag = a_mag / b_safe;
    assign r_mag = a_mag % b_safe;

    // Truncation toward zero; remainder follows the dividend's sign
    assign quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem  = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        hi_res_o = 32'd0;
        lo_res_o = 32'd0;
        unique case (op_i)
            MD_MULT:  {hi_res_o, lo_res_o} = prod_s;
            MD_MULTU: {hi_res_o, lo_res_o} = prod_u;
            default: begin
                hi_res_o = rem;
                lo_res_o = quot;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_seq
//  Description : Multiply/divide sequencer. Launches multi-cycle MDU ops on
//                latched operands, owns HI/LO and serves mfhi/mflo reads.
//  Ports       : clk_i      clock, rising edge
//                reset_i    synchronous active-high reset
//                start_i    launch op given by md_op_i (IDLE only)
//                md_op_i    MD_MULT / MD_MULTU / MD_DIV / MD_DIVU
//                mt_hi_i    write rs_val_i to HI (IDLE only)
//                mt_lo_i    write rs_val_i to LO (IDLE only)
//                rs_val_i   rs operand
//                rt_val_i   rt operand
//                mf_sel_i   read select, 1 = HI, 0 = LO
//                mf_data_o  registered HI or LO per mf_sel_i
//                busy_o     operation in flight
//                hi_o/lo_o  architectural HI/LO
//  Revision    : 1.0  initial release
// ============================================================================
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [1:0]  md_op_i,
    input  logic        mt_hi_i,
    input  logic        mt_lo_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    input  logic        mf_sel_i,
    output logic [31:0] mf_data_o,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      rs_q,    rs_d;
    logic [31:0]      rt_q,    rt_d;
    md_op_e           op_q,    op_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    logic [31:0]      hi_res;
    logic [31:0]      lo_res;
    logic             div_zero;
    md_op_e           op_in;

    assign op_in = md_op_e'(md_op_i);

    mdu_arith u_arith (
        .a_i        (rs_q),
        .b_i        (rt_q),
        .op_i       (op_q),
        .hi_res_o   (hi_res),
        .lo_res_o   (lo_res),
        .div_zero_o (div_zero)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            op_q    <= MD_MULT;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    // start has priority; a same-cycle mt_* is dropped
                    rs_d    = rs_val_i;
                    rt_d    = rt_val_i;
                    op_d    = op_in;
                    cnt_d   = (op_in == MD_MULT || op_in == MD_MULTU)
                              ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    state_d = ST_RUN;
                end else begin
                    if (mt_hi_i) hi_d = rs_val_i;
                    if (mt_lo_i) lo_d = rs_val_i;
                end
            end
            ST_RUN: begin
                // start / mt_* are ignored here; the hazard unit holds them in D
                if (cnt_q == CNT_W'(1)) begin
                    // divide by zero runs full length but leaves HI/LO alone
                    if (!(div_zero && (op_q == MD_DIV || op_q == MD_DIVU))) begin
                        hi_d = hi_res;
                        lo_d = lo_res;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o    = (state_q == ST_RUN);
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign mf_data_o = mf_sel_i ? hi_q : lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_seq
//  Description : Self-checking bench for mdu_seq. Stimulus pushes expected
//                HI/LO/latency per launched op into a scoreboard; a monitor
//                pops and compares whenever an op completes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mdu_seq;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'd0;
    logic        mt_hi = 1'b0;
    logic        mt_lo = 1'b0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        mf_sel = 1'b0;
    logic [31:0] mf_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_seq #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .start_i   (start),
        .md_op_i   (md_op),
        .mt_hi_i   (mt_hi),
        .mt_lo_i   (mt_lo),
        .rs_val_i  (rs_val),
        .rt_val_i  (rt_val),
        .mf_sel_i  (mf_sel),
        .mf_data_o (mf_data),
        .busy_o    (busy),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi = 32'd0;   // reference model of architectural HI/LO
    logic [31:0] m_lo = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the architectural rules
    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          p, q, r;
        longint unsigned up;
        exp_t            e;
        case (op)
            2'd0: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; end
            2'd1: begin up = longint'(a) * longint'(b); {m_hi, m_lo} = up; end
            2'd2: if (b != 0) begin
                q = longint'($signed(a)) / longint'($signed(b));
                r = longint'($signed(a)) % longint'($signed(b));
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            default: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        e.n  = (op < 2'd2) ? MULT_N : DIV_N;
        sb.push_back(e);
    endtask

    // Monitor: measures each busy window and checks the committed result
    int run_len = 0;
    always @(negedge clk) begin
        if (reset) begin
            run_len = 0;
        end else if (busy) begin
            run_len++;
        end else if (run_len > 0) begin
            if (sb.size() == 0) begin
                chk("unexpected_completion", 64'(run_len), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("busy_cycles", 64'(run_len), 64'(e.n));
                chk("hi_result", {32'd0, hi}, {32'd0, e.hi});
                chk("lo_result", {32'd0, lo}, {32'd0, e.lo});
                chk("mf_data_result", {32'd0, mf_data}, {32'd0, mf_sel ? e.hi : e.lo});
            end
            run_len = 0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Launch an op (DUT must be idle); optional same-cycle mt_lo
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic with_mt);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        mt_lo  = with_mt;
        model_op(op, a, b);
        cyc();
        start = 1'b0;
        mt_lo = 1'b0;
    endtask

    // Wait for busy to drop; scramble operands meanwhile
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            rs_val = $urandom;
            rt_val = $urandom;
            cyc();
            n++;
        end
        if (busy) chk("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [31:0] v);
        mt_hi  = wh;
        mt_lo  = wl;
        rs_val = v;
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        cyc();
        mt_hi = 1'b0;
        mt_lo = 1'b0;
        chk("mt_hi_val", {32'd0, hi}, {32'd0, m_hi});
        chk("mt_lo_val", {32'd0, lo}, {32'd0, m_lo});
    endtask

    initial begin
        logic [31:0] old_lo;
        logic [31:0] a, b;
        logic [1:0]  op;

        repeat (2) cyc();
        reset = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        chk("reset_mf_lo", {32'd0, mf_data}, 64'd0);
        mf_sel = 1'b1;
        #1;
        chk("reset_mf_hi", {32'd0, mf_data}, 64'd0);

        // MULT -1 * 2, then MULTU, then back-to-back DIV -7 / 2
        issue(2'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        wait_idle();
        issue(2'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        wait_idle();
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_idle();

        // Divide by zero leaves HI/LO untouched
        mt_write(1'b1, 1'b0, 32'h1234);
        mt_write(1'b0, 1'b1, 32'h5678);
        issue(2'd3, 32'd100, 32'd0, 1'b0);
        wait_idle();

        // Signed overflow case
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle();

        // start + mt_lo during RUN are ignored
        issue(2'd2, 32'd1000, 32'd7, 1'b0);
        cyc();
        start = 1'b1; md_op = 2'd0; mt_lo = 1'b1; rs_val = 32'hAAAA;
        cyc();
        start = 1'b0; mt_lo = 1'b0;
        wait_idle();

        // Reset mid-MULT discards the op
        issue(2'd0, 32'd9, 32'd9, 1'b0);
        repeat (3) cyc();
        reset = 1'b1;
        sb.delete();
        cyc();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("midrun_reset_busy", {63'd0, busy}, 64'd0);
        chk("midrun_reset_hi", {32'd0, hi}, 64'd0);
        chk("midrun_reset_lo", {32'd0, lo}, 64'd0);
        issue(2'd0, 32'd3, 32'd4, 1'b0);
        chk("start_after_reset", {63'd0, busy}, 64'd1);
        wait_idle();

        // mf_data has no bypass of a same-cycle mt
        mf_sel = 1'b1;
        mt_hi  = 1'b1;
        rs_val = 32'hDEAD_BEEF;
        #1;
        chk("mf_old_hi", {32'd0, mf_data}, {32'd0, m_hi});
        m_hi = 32'hDEAD_BEEF;
        cyc();
        mt_hi = 1'b0;
        chk("mf_new_hi", {32'd0, mf_data}, 64'h0000_0000_DEAD_BEEF);

        // start wins over same-cycle mt_lo
        old_lo = m_lo;
        issue(2'd1, 32'h0001_0000, 32'h0001_0000, 1'b1);
        chk("start_beats_mt_lo", {32'd0, lo}, {32'd0, old_lo});
        wait_idle();

        // Randomized ops with occasional mt writes and corner operands
        for (int i = 0; i < 40; i++) begin
            mf_sel = 1'($urandom);
            if ($urandom_range(0, 3) == 0)
                mt_write(1'($urandom), 1'($urandom), $urandom);
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: a = 32'($urandom_range(0, 50));
                default: ;
            endcase
            issue(op, a, b, 1'b0);
            wait_idle();
        end

        repeat (3) cyc();
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mdu_seq.md
# mdu_seq

Sequencer for the multiply/divide unit in the five-stage pipeline. Accepts mult/multu/div/divu/mthi/mtlo from the E stage, runs multi-cycle operations on latched operands, owns the HI/LO registers, and serves mfhi/mflo reads. Its `start` input and `busy` output are the signals the hazard unit uses to hold any MDU-class instruction in D.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥1).

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  E-stage pulse: launch a multi-cycle operation this cycle.
- `md_op`  in  2  with `start`: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `mt_hi`  in  1  write `rs_val` to HI this cycle.
- `mt_lo`  in  1  write `rs_val` to LO this cycle.
- `rs_val`  in  32  forwarded rs operand.
- `rt_val`  in  32  forwarded rt operand.
- `mf_sel`  in  1  read select: 1 HI, 0 LO.
- `mf_data`  out  32  combinational HI or LO per `mf_sel`.
- `busy`  out  1  an operation is in flight.
- `hi`, `lo`  out  32 each  architectural HI/LO register values.

## Operation
- States: IDLE, RUN. Counter is wide enough for `max(MULT_CYCLES, DIV_CYCLES)`.
- IDLE + `start`:
  - latch `rs_val`, `rt_val`, `md_op`;
  - load the counter with the op's cycle count;
  - go to RUN.
- RUN: the counter decrements each cycle. When the counter reaches 1:
  - commit the result to HI/LO;
  - go to IDLE.
- `busy` is 1 exactly while in RUN.
- MULT/MULTU: the 64-bit product (signed or unsigned) goes to {HI, LO}.
- DIV/DIVU:
  - LO = quotient, HI = remainder;
  - signed division truncates toward zero; the remainder takes the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
- Divisor 0: the op runs its full DIV_CYCLES with `busy` asserted, and HI/LO are left unchanged.
- `mt_hi` / `mt_lo` in IDLE: the register updates at the clock edge. `mt_hi` and `mt_lo` together write both registers.
- `start` or `mt_*` while in RUN is ignored; the in-flight op is unaffected. The hazard unit guarantees this does not occur.
- `start` and `mt_*` in the same IDLE cycle: `start` wins and the `mt_*` is dropped.
- `mf_data` always reflects the current registered HI/LO. There is no bypass of a same-cycle `mt_*` or commit.
- Reset (in any state, including mid-RUN):
  - state = IDLE, counter = 0, `busy` = 0;
  - HI = 0, LO = 0, latched operands = 0;
  - the in-flight op is discarded.

## Timing
- `start` sampled at edge T: `busy` = 1 for cycles T+1 … T+N, with N = MULT_CYCLES or DIV_CYCLES.
- Result is written at the edge ending cycle T+N. HI/LO are visible and `busy` = 0 from cycle T+N+1.
- Back-to-back: a new `start` is accepted in cycle T+N+1.
- `mt_*` at edge T: the new value is visible on `hi`/`lo`/`mf_data` in cycle T+1.
- Operands are captured at the `start` edge. Changes on `rs_val`/`rt_val` during RUN have no effect.
- Reset values: `busy` = 0, `hi` = 0, `lo` = 0, `mf_data` = 0.

## Structure
- Shared package `mdu_pkg`:
  - md_op encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`);
  - state encoding;
  - default latency constants.
- The CU decoder and the stall unit use the same encodings.
- Sub-module `mdu_arith`: purely combinational. Takes latched operands and op; produces `{hi_res, lo_res, div_zero}`.
- The sequencer holds the FSM, counter, HI/LO registers and the read mux.

## Test plan
- Reset, then `start` MULT with rs = 0xFFFFFFFF, rt = 2 → `busy` high 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- `start` MULTU with the same operands → HI = 0x00000001, LO = 0xFFFFFFFE after 5 cycles. Immediately `start` DIV with rs = −7 (0xFFFFFFF9), rt = 2 → accepted at T+6; 10 cycles later LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU with rs = 100, rt = 0 after `mt_hi` = 0x1234, `mt_lo` = 0x5678 → `busy` for 10 cycles; HI/LO stay 0x1234/0x5678.
- `start` DIV, then pulse `mt_lo` = 0xAAAA and `start` MULT at cycle T+3 → both ignored; the DIV result commits at T+10 and `busy` falls at T+11.
- Assert `reset` at T+4 of a MULT → cycle after reset: `busy` = 0, HI = LO = 0; a new `start` is accepted the next cycle.
- `mt_hi` = 0xDEADBEEF with `mf_sel` = 1 → `mf_data` shows the old HI in cycle T and 0xDEADBEEF in T+1. Same-cycle `start` + `mt_lo` → LO unchanged by the `mt`.
